tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
Sequencer for the carrier/LO frequency generator. It buffers a list of tones (frequency word plus duration in output samples), starts the generator, and retunes f_c at sample boundaries. It stops the generator after the last tone, or on abort or underrun. It sits between the register/host interface and the generator, and owns the generator's start, reset and f_c inputs.

Parameters:
FIFO_DEPTH, 8, tone buffer entries (power of 2, ≥2)
DUR_W, 16, width of tone duration field (samples)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
tone_valid  in  1  push request
tone_ready  out  1  buffer can accept
tone_fc  in  30  frequency word for tone
tone_dur  in  DUR_W  tone length in samples, 0 treated as 1
tone_last  in  1  final tone of sequence
go  in  1  start sequence (level sampled in IDLE)
abort  in  1  stop immediately
osr_level  in  2  0:32, 1:64, 2:128, 3:256 cycles per sample
gen_active  in  1  generator active status
gen_start  out  1  one-cycle start pulse to generator
gen_reset_n  out  1  generator reset, active-low
gen_f_c  out  30  frequency word to generator
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on sequence end (last tone, abort or underrun)
underrun  out  1  sticky; cleared on next go
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries buffered

Behaviour:
- Reset values: tone_ready=1, gen_start=0, gen_reset_n=0, gen_f_c=0, busy=0, done=0, underrun=0, fifo_level=0, state=IDLE.
- gen_reset_n is released the first cycle after reset deasserts.
- FIFO entry is {fc, dur, last}.
  - Push when tone_valid&&tone_ready.
  - tone_ready = level<FIFO_DEPTH.
  - Simultaneous push and pop keeps level unchanged.
- Sample period P = 32<<osr_level cycles. osr_level is sampled at go and held for the sequence.
- Sample counter counts P-1 down to 0. Tone counter counts samples remaining.
- States:
  - IDLE: if go && level>0 → pop head into gen_f_c and tone counter, clear underrun, go to LAUNCH. go with an empty FIFO is ignored.
  - LAUNCH: gen_start=1 for exactly one cycle → WAIT_ACT.
  - WAIT_ACT: on gen_active=1, load sample counter with P-1 → RUN. If 64 cycles pass without gen_active → STOP, set underrun.
  - RUN: sample counter decrements each cycle. At 0 it reloads and the tone counter decrements. When the final sample of a tone ends:
    - current last=1 → STOP.
    - else level>0 → pop, update gen_f_c in that same cycle, reload tone counter.
    - else → set underrun, go to STOP.
  - STOP: gen_reset_n=0 for 2 cycles, done=1 in the first of them → IDLE.
- abort in any non-IDLE state → STOP next cycle. The FIFO is not flushed; remaining entries are kept.
- abort in IDLE flushes the FIFO (level→0).
- A push arriving in the same cycle as the final-sample pop is visible to that pop only if level was already >0. A just-written entry is never popped the same cycle.
- reset_n low mid-operation: all state returns to reset values and the FIFO empties.
- Total tone time = dur·P cycles measured from the RUN entry or retune cycle.

Optional Feature:
TONE_SEQ_LOOP_EN
- Defined: adds input port loop_en (1 bit). While busy&&loop_en:
  - Each popped entry is re-written at the FIFO tail in the same cycle, so level stays constant.
  - tone_last is ignored for stopping; the sequence repeats until abort.
  - tone_ready=0 while busy.
- Undefined: no loop_en port; behaviour as above.

Decomposition:
Package tone_seq_pkg holds:
- state enum (IDLE, LAUNCH, WAIT_ACT, RUN, STOP)
- tone entry struct
- ACT_TIMEOUT=64, STOP_CYCLES=2
- function osr_period(level)

Sub-module tone_fifo (sync FIFO with push, pop, level, flush, and same-cycle pop+push) is natural.

Test Plan:
1. Push {fc=0x100,dur=2,last=0},{fc=0x200,dur=1,last=1}; osr_level=0; go; gen_active tied to gen_start-delayed-by-2 → gen_start single pulse; gen_f_c=0x100 for 64 cycles after RUN entry, then 0x200 for 32 cycles. STOP: gen_reset_n low 2 cycles, done pulse, underrun=0.
2. Push one tone {dur=3,last=0}, osr_level=1 → after 192 RUN cycles underrun=1, done=1, state IDLE. Next go with a new entry clears underrun.
3. Push 8 entries → tone_ready=0, fifo_level=8. A 9th push attempt is dropped. Pop plus push in the same cycle keeps level=8.
4. abort 10 cycles into RUN with 3 entries queued → STOP next cycle, done pulse, fifo_level=3. abort in IDLE → fifo_level=0.
5. gen_active held 0 after go → 64 cycles in WAIT_ACT, then underrun=1, gen_reset_n low 2 cycles.
6. (LOOP_EN) loop_en=1, two tones dur=1, osr_level=0 → gen_f_c alternates every 32 cycles for ≥4 periods, fifo_level stays 2. abort → done, IDLE.

Source files
------------

// File: rtl/tone_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tone_seq_pkg
// Purpose  : Shared types, constants and helpers for the tone sequencer.
//            State encodings, the tone control fields held per FIFO entry,
//            generator handshake timing and the OSR sample-period helper.
// Revision : 1.0 - initial release
// ============================================================================
package tone_seq_pkg;

  localparam int TONE_FC_W   = 30;
  localparam int ACT_TIMEOUT = 64;
  localparam int STOP_CYCLES = 2;

  // Sequencer states
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LAUNCH   = 3'd1;
  localparam logic [2:0] S_WAIT_ACT = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_STOP     = 3'd4;

  // Per-tone control fields; the duration field sits below these in a
  // FIFO entry because its width is a sequencer parameter.
  typedef struct packed {
    logic [TONE_FC_W-1:0] fc;
    logic                 last;
  } tone_ctl_t;

  // Generator clock cycles per output sample: 32, 64, 128 or 256.
  function automatic logic [8:0] osr_period(input logic [1:0] level);
    return 9'd32 << level;
  endfunction

endpackage : tone_seq_pkg
`default_nettype wire

// File: rtl/tone_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tone_fifo
// Purpose  : Synchronous FIFO for tone entries. Supports simultaneous push
//            and pop (including push into a full FIFO when a pop frees the
//            slot in the same cycle) and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module tone_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;
  logic             w_pop;
  logic             w_push;

  // A pop never sees the entry written in the same cycle, since it is gated
  // by the registered level.
  assign w_pop  = i_pop && (r_level != '0);
  assign w_push = i_push && !i_flush && ((r_level != FULL) || w_pop);

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule : tone_fifo
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tone_sequencer
// Purpose  : Buffers tones (frequency word, duration in samples, last flag),
//            starts the carrier/LO generator, retunes f_c on sample
//            boundaries and stops the generator after the last tone, on
//            abort, or on underrun.
// Options  : TONE_SEQ_LOOP_EN - adds loop_en; popped tones are re-queued and
//            the sequence repeats until abort.
// Revision : 1.0 - initial release
// ============================================================================
module tone_sequencer
  import tone_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DUR_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tone_valid,
  output logic                        tone_ready,
  input  logic [TONE_FC_W-1:0]        tone_fc,
  input  logic [DUR_W-1:0]            tone_dur,
  input  logic                        tone_last,
  input  logic                        go,
  input  logic                        abort,
`ifdef TONE_SEQ_LOOP_EN
  input  logic                        loop_en,
`endif
  input  logic [1:0]                  osr_level,
  input  logic                        gen_active,
  output logic                        gen_start,
  output logic                        gen_reset_n,
  output logic [TONE_FC_W-1:0]        gen_f_c,
  output logic                        busy,
  output logic                        done,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = TONE_FC_W + 1 + DUR_W;
  localparam int WAIT_W  = $clog2(ACT_TIMEOUT);

  logic [2:0]           r_state;
  logic [1:0]           r_osr;
  logic [7:0]           r_samp_cnt;
  logic [DUR_W-1:0]     r_tone_cnt;
  logic                 r_last;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [1:0]           r_stop_cnt;
  logic                 r_gen_start;
  logic                 r_gen_reset_n;
  logic [TONE_FC_W-1:0] r_gen_fc;
  logic                 r_done;
  logic                 r_underrun;

  logic [ENTRY_W-1:0]   w_head;
  logic [ENTRY_W-1:0]   w_push_data;
  tone_ctl_t            w_head_ctl;
  logic [DUR_W-1:0]     w_head_dur;
  logic [DUR_W-1:0]     w_head_len;
  logic [LW-1:0]        w_level;
  logic [7:0]           w_reload;
  logic [8:0]           w_period;
  logic                 w_loop_en;
  logic                 w_idle;
  logic                 w_final;
  logic                 w_launch;
  logic                 w_retune;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_loop_wr;
  logic                 w_flush;
  logic                 w_set_ur;
  logic [2:0]           w_state_nxt;

`ifdef TONE_SEQ_LOOP_EN
  assign w_loop_en = loop_en;
`else
  assign w_loop_en = 1'b0;
`endif

  assign w_head_ctl = w_head[ENTRY_W-1:DUR_W];
  assign w_head_dur = w_head[DUR_W-1:0];
  assign w_head_len = (w_head_dur == '0) ? DUR_W'(1) : w_head_dur;
  assign w_period   = osr_period(r_osr);
  assign w_reload   = 8'(w_period - 9'd1);
  assign w_idle     = (r_state == S_IDLE);
  assign w_final    = (r_samp_cnt == 8'd0) && (r_tone_cnt == DUR_W'(1));
  assign w_flush    = w_idle && abort;

  // Next-state decision and the pop/underrun events it implies
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_retune    = 1'b0;
    w_set_ur    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!abort && go && (w_level != '0)) begin
          w_launch    = 1'b1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_nxt = abort ? S_STOP : S_WAIT_ACT;
      end
      S_WAIT_ACT: begin
        if (abort) begin
          w_state_nxt = S_STOP;
        end else if (gen_active) begin
          w_state_nxt = S_RUN;
        end else if (r_wait_cnt == WAIT_W'(ACT_TIMEOUT - 1)) begin
          w_state_nxt = S_STOP;
          w_set_ur    = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_STOP;
        end else if (w_final) begin
          if (r_last && !w_loop_en) begin
            w_state_nxt = S_STOP;
          end else if (w_level != '0) begin
            w_retune = 1'b1;
          end else begin
            w_state_nxt = S_STOP;
            w_set_ur    = 1'b1;
          end
        end
      end
      S_STOP: begin
        if (r_stop_cnt == 2'(STOP_CYCLES - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // In loop mode every popped tone, including the one taken at launch, is
  // written straight back so the list keeps cycling; host pushes are then
  // blocked so the two writers never collide.
  assign w_pop       = w_launch || w_retune;
  assign w_loop_wr   = w_loop_en && w_pop;
  assign tone_ready  = (w_level < LW'(FIFO_DEPTH)) &&
                       !(w_loop_en && (!w_idle || w_launch));
  assign w_push      = w_loop_wr || (tone_valid && tone_ready && !w_flush);
  assign w_push_data = w_loop_wr ? w_head : {tone_fc, tone_last, tone_dur};

  tone_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_flush     (w_flush),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (w_level)
  );

  // State, counters and generator-facing registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_osr         <= 2'd0;
      r_samp_cnt    <= 8'd0;
      r_tone_cnt    <= '0;
      r_last        <= 1'b0;
      r_wait_cnt    <= '0;
      r_stop_cnt    <= 2'd0;
      r_gen_start   <= 1'b0;
      r_gen_reset_n <= 1'b0;
      r_gen_fc      <= '0;
      r_done        <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_gen_start   <= w_launch;
      r_done        <= (w_state_nxt == S_STOP) && (r_state != S_STOP);
      // Held low for the whole STOP window, released otherwise
      r_gen_reset_n <= (w_state_nxt != S_STOP);

      if (w_launch) r_osr <= osr_level;

      if (w_pop) begin
        r_gen_fc   <= w_head_ctl.fc;
        r_last     <= w_head_ctl.last;
        r_tone_cnt <= w_head_len;
      end else if ((r_state == S_RUN) && (r_samp_cnt == 8'd0)) begin
        r_tone_cnt <= r_tone_cnt - 1'b1;
      end

      if (r_state == S_WAIT_ACT) begin
        r_samp_cnt <= w_reload;
      end else if (r_state == S_RUN) begin
        r_samp_cnt <= (r_samp_cnt == 8'd0) ? w_reload : r_samp_cnt - 8'd1;
      end

      r_wait_cnt <= (r_state == S_WAIT_ACT) ? r_wait_cnt + 1'b1 : '0;
      r_stop_cnt <= (r_state == S_STOP) ? r_stop_cnt + 2'd1 : 2'd0;

      if (w_launch)      r_underrun <= 1'b0;
      else if (w_set_ur) r_underrun <= 1'b1;
    end
  end

  assign gen_start   = r_gen_start;
  assign gen_reset_n = r_gen_reset_n;
  assign gen_f_c     = r_gen_fc;
  assign busy        = !w_idle;
  assign done        = r_done;
  assign underrun    = r_underrun;
  assign fifo_level  = w_level;

endmodule : tone_sequencer
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tone_sequencer
// Purpose  : Self-checking bench for tone_sequencer. Directed tone lists are
//            issued by the stimulus process together with the generator
//            events they should produce (start, retune, done); a monitor
//            compares each event as the DUT presents it.
// Options  : TONE_SEQ_LOOP_EN - also exercises loop mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;
  import tone_seq_pkg::*;

  localparam int FIFO_DEPTH = 8;
  localparam int DUR_W      = 16;
  localparam int EV_START   = 0;
  localparam int EV_RETUNE  = 1;
  localparam int EV_DONE    = 2;

  typedef struct {
    int          kind;
    logic [29:0] fc;
    int          delta;
    logic        ur;
    int          level;
  } ev_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              tone_valid = 1'b0;
  logic              tone_ready;
  logic [29:0]       tone_fc = '0;
  logic [DUR_W-1:0]  tone_dur = '0;
  logic              tone_last = 1'b0;
  logic              go = 1'b0;
  logic              abort = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
  logic              loop_en = 1'b0;
`endif
  logic [1:0]        osr_level = 2'd0;
  logic              gen_active = 1'b0;
  logic              gen_start;
  logic              gen_reset_n;
  logic [29:0]       gen_f_c;
  logic              busy;
  logic              done;
  logic              underrun;
  logic [3:0]        fifo_level;

  logic              gen_en = 1'b1;
  logic              gen_d1 = 1'b0;
  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  int                post = 0;
  ev_t               exp_q[$];

  tone_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DUR_W      (DUR_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tone_valid  (tone_valid),
    .tone_ready  (tone_ready),
    .tone_fc     (tone_fc),
    .tone_dur    (tone_dur),
    .tone_last   (tone_last),
    .go          (go),
    .abort       (abort),
`ifdef TONE_SEQ_LOOP_EN
    .loop_en     (loop_en),
`endif
    .osr_level   (osr_level),
    .gen_active  (gen_active),
    .gen_start   (gen_start),
    .gen_reset_n (gen_reset_n),
    .gen_f_c     (gen_f_c),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: goes active two cycles after the start pulse
  always @(posedge clk) begin
    if (!gen_reset_n || !gen_en) begin
      gen_d1     <= 1'b0;
      gen_active <= 1'b0;
    end else begin
      if (gen_start) gen_d1 <= 1'b1;
      gen_active <= gen_d1;
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic expect_ev(input int kind, input logic [29:0] fc, input int delta,
                           input logic ur, input int level);
    ev_t e;
    e.kind = kind; e.fc = fc; e.delta = delta; e.ur = ur; e.level = level;
    exp_q.push_back(e);
  endtask

  // All stimulus tasks start and end just after a falling edge
  task automatic push(input logic [29:0] fc, input int dur, input logic last);
    tone_valid = 1'b1; tone_fc = fc; tone_dur = DUR_W'(dur); tone_last = last;
    @(negedge clk);
    tone_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || post != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || post != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d events pending after %0d cycles, expected 0",
               name, exp_q.size(), budget);
      exp_q.delete();
      post = 0;
    end
  endtask

  // Monitor: pops the expected event whenever the DUT presents one
  initial begin : monitor
    ev_t         e;
    logic [29:0] prev_fc;
    int          t0;
    int          kind;
    logic        start_chk;
    prev_fc   = '0;
    t0        = 0;
    start_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_fc   = gen_f_c;
        start_chk = 1'b0;
        continue;
      end
      if (start_chk) begin
        chk("start_pulse_width", 64'(gen_start), 64'd0);
        start_chk = 1'b0;
      end
      if (post == 1) begin
        chk("stop_rst_cycle2", 64'(gen_reset_n), 64'd0);
        chk("done_pulse_width", 64'(done), 64'd0);
        post = 2;
      end else if (post == 2) begin
        chk("stop_release", 64'(gen_reset_n), 64'd1);
        chk("idle_after_stop", 64'(busy), 64'd0);
        post = 0;
      end
      if (gen_start || done || (busy && gen_f_c != prev_fc)) begin
        kind = gen_start ? EV_START : (done ? EV_DONE : EV_RETUNE);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d fc=0x%0h, expected none", kind, gen_f_c);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", 64'(kind), 64'(e.kind));
          if (kind == e.kind) begin
            case (kind)
              EV_START: begin
                t0 = cyc;
                start_chk = 1'b1;
                chk("start_fc", 64'(gen_f_c), 64'(e.fc));
                chk("start_underrun_clr", 64'(underrun), 64'd0);
              end
              EV_RETUNE: begin
                chk("retune_fc", 64'(gen_f_c), 64'(e.fc));
                chk("retune_time", 64'(cyc - t0), 64'(e.delta));
                chk("retune_level", 64'(fifo_level), 64'(e.level));
              end
              default: begin
                chk("done_time", 64'(cyc - t0), 64'(e.delta));
                chk("done_underrun", 64'(underrun), 64'(e.ur));
                chk("done_level", 64'(fifo_level), 64'(e.level));
                chk("stop_rst_cycle1", 64'(gen_reset_n), 64'd0);
                post = 1;
              end
            endcase
          end
        end
      end
      prev_fc = gen_f_c;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_tone_ready",  64'(tone_ready),  64'd1);
    chk("rst_gen_start",   64'(gen_start),   64'd0);
    chk("rst_gen_reset_n", 64'(gen_reset_n), 64'd0);
    chk("rst_gen_f_c",     64'(gen_f_c),     64'd0);
    chk("rst_busy",        64'(busy),        64'd0);
    chk("rst_done",        64'(done),        64'd0);
    chk("rst_underrun",    64'(underrun),    64'd0);
    chk("rst_fifo_level",  64'(fifo_level),  64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("gen_reset_release", 64'(gen_reset_n), 64'd1);

    // Two-tone sequence at P=32: RUN entry 3 cycles after start pulse
    push(30'h100, 2, 1'b0);
    push(30'h200, 1, 1'b1);
    chk("t1_level", 64'(fifo_level), 64'd2);
    osr_level = 2'd0;
    expect_ev(EV_START,  30'h100, 0,  1'b0, 0);
    expect_ev(EV_RETUNE, 30'h200, 67, 1'b0, 0);
    expect_ev(EV_DONE,   30'h0,   99, 1'b0, 0);
    pulse_go();
    wait_drain(300, "t1");

    // Underrun after a non-last tone, P=64, then cleared on next go
    push(30'h300, 3, 1'b0);
    osr_level = 2'd1;
    expect_ev(EV_START, 30'h300, 0,   1'b0, 0);
    expect_ev(EV_DONE,  30'h0,   195, 1'b1, 0);
    pulse_go();
    wait_drain(400, "t2");
    chk("t2_underrun_sticky", 64'(underrun), 64'd1);
    chk("t2_idle", 64'(busy), 64'd0);
    push(30'h310, 0, 1'b1);
    chk("t2_underrun_held", 64'(underrun), 64'd1);
    osr_level = 2'd0;
    expect_ev(EV_START, 30'h310, 0,  1'b0, 0);
    expect_ev(EV_DONE,  30'h0,   35, 1'b0, 0);
    pulse_go();
    wait_drain(200, "t2b");
    chk("t2_underrun_after", 64'(underrun), 64'd0);

    // Fill to full, drop an extra push, flush with abort in IDLE
    for (int i = 0; i < 8; i++) push(30'h500 + 30'(i), 1, (i == 7));
    chk("t3_full_level", 64'(fifo_level), 64'd8);
    chk("t3_full_ready", 64'(tone_ready), 64'd0);
    push(30'h5ff, 1, 1'b1);
    chk("t3_overflow_drop", 64'(fifo_level), 64'd8);
    pulse_abort();
    chk("t3_flush_level", 64'(fifo_level), 64'd0);
    chk("t3_flush_ready", 64'(tone_ready), 64'd1);

    // Launch pop with a same-cycle push, then abort 10 cycles into RUN
    push(30'h400, 5, 1'b0);
    push(30'h410, 5, 1'b0);
    push(30'h420, 5, 1'b1);
    expect_ev(EV_START, 30'h400, 0,  1'b0, 0);
    expect_ev(EV_DONE,  30'h0,   13, 1'b0, 3);
    go = 1'b1; tone_valid = 1'b1; tone_fc = 30'h430; tone_dur = 16'd5; tone_last = 1'b0;
    @(negedge clk);
    go = 1'b0; tone_valid = 1'b0;
    chk("t4_pop_push_level", 64'(fifo_level), 64'd3);
    repeat (12) @(negedge clk);
    pulse_abort();
    wait_drain(100, "t4");
    chk("t4_kept_level", 64'(fifo_level), 64'd3);
    pulse_abort();
    chk("t4_idle_flush", 64'(fifo_level), 64'd0);

    // Generator never goes active: timeout after 64 WAIT_ACT cycles
    gen_en = 1'b0;
    push(30'h600, 1, 1'b1);
    expect_ev(EV_START, 30'h600, 0,  1'b0, 0);
    expect_ev(EV_DONE,  30'h0,   65, 1'b1, 0);
    pulse_go();
    wait_drain(200, "t5");
    gen_en = 1'b1;
    chk("t5_underrun", 64'(underrun), 64'd1);

    // Reset in the middle of a tone
    push(30'h800, 4, 1'b0);
    push(30'h810, 1, 1'b1);
    expect_ev(EV_START, 30'h800, 0, 1'b0, 0);
    pulse_go();
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_level",   64'(fifo_level),  64'd0);
    chk("mid_rst_busy",    64'(busy),        64'd0);
    chk("mid_rst_gen_rst", 64'(gen_reset_n), 64'd0);
    chk("mid_rst_fc",      64'(gen_f_c),     64'd0);
    chk("mid_rst_ur",      64'(underrun),    64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_release", 64'(gen_reset_n), 64'd1);
    wait_drain(10, "t_rst");

`ifdef TONE_SEQ_LOOP_EN
    // Loop mode: two one-sample tones alternate until abort
    loop_en = 1'b1;
    push(30'h700, 1, 1'b1);
    push(30'h710, 1, 1'b1);
    expect_ev(EV_START,  30'h700, 0,   1'b0, 0);
    expect_ev(EV_RETUNE, 30'h710, 35,  1'b0, 2);
    expect_ev(EV_RETUNE, 30'h700, 67,  1'b0, 2);
    expect_ev(EV_RETUNE, 30'h710, 99,  1'b0, 2);
    expect_ev(EV_RETUNE, 30'h700, 131, 1'b0, 2);
    expect_ev(EV_DONE,   30'h0,   141, 1'b0, 2);
    pulse_go();
    chk("t6_launch_level", 64'(fifo_level), 64'd2);
    repeat (5) @(negedge clk);
    chk("t6_ready_blocked", 64'(tone_ready), 64'd0);
    repeat (135) @(negedge clk);
    pulse_abort();
    wait_drain(100, "t6");
    loop_en = 1'b0;
    chk("t6_kept_level", 64'(fifo_level), 64'd2);
    pulse_abort();
    chk("t6_flush", 64'(fifo_level), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tone_sequencer
`default_nettype wire
